// File: rtl/combi_pkg.sv
// rtl/combi_pkg.sv - opcodes, FSM states and default width for the sequential ALU
package combi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/combi_seq_alu_if.sv
// rtl/combi_seq_alu_if.sv - operand/result handshake bundle for the sequential ALU
import combi_pkg::*;

interface combi_seq_alu_if #(
  parameter int DATA_W = DATA_W_DEF
);
  logic                  i_valid;
  logic                  o_ready;
  logic [1:0]            i_op;
  logic [DATA_W-1:0]     i_a;
  logic [DATA_W-1:0]     i_b;
  logic                  o_valid;
  logic                  i_ready;
  logic [2*DATA_W-1:0]   o_result;
  logic [DATA_W-1:0]     o_rem;
  logic                  o_div_by_zero;

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_rem, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_rem, o_div_by_zero
  );
endinterface

// File: rtl/combi_div_seq.sv
// rtl/combi_div_seq.sv - restoring shift-subtract divider, one quotient bit per cycle
import combi_pkg::*;

module combi_div_seq #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] trial;
  logic              fits;

  // quotient/remainder are the values after the step taken on the coming edge,
  // so the parent can register the final answer on the same edge as done.
  assign shifted   = {rem_q, quo_q[DATA_W-1]};
  assign fits      = shifted >= {1'b0, div_q};
  assign trial     = shifted[DATA_W-1:0] - div_q;
  assign remainder = fits ? trial : shifted[DATA_W-1:0];
  assign quotient  = {quo_q[DATA_W-2:0], fits};
  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= CNT_W'(DATA_W);
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/combi_seq_alu.sv
// rtl/combi_seq_alu.sv - handshaked ALU: single-cycle add/sub/mul, multi-cycle divide
import combi_pkg::*;

module combi_seq_alu #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  combi_seq_alu_if.slave   bus
);
  state_e                state;
  logic                  ready_q;
  logic                  valid_q;
  logic [2*DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]     rem_q;
  logic                  dbz_q;

  logic                  accept;
  logic                  div_load;
  logic                  div_busy;
  logic                  div_done;
  logic [DATA_W-1:0]     div_quo;
  logic [DATA_W-1:0]     div_rem;

  logic [DATA_W:0]       sum_w;
  logic [DATA_W-1:0]     diff_w;
  logic [2*DATA_W-1:0]   prod_w;
  logic [2*DATA_W-1:0]   alu_res;

  assign accept   = bus.i_valid && ready_q;
  assign div_load = accept && (bus.i_op == OP_DIV) && (bus.i_b != '0);

  assign sum_w  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
  assign diff_w = bus.i_a - bus.i_b;
  assign prod_w = (2*DATA_W)'(bus.i_a) * (2*DATA_W)'(bus.i_b);

  always_comb begin
    alu_res = '0;
    case (bus.i_op)
      OP_ADD:  alu_res = (2*DATA_W)'(sum_w);
      OP_SUB:  alu_res = (2*DATA_W)'(diff_w);
      OP_MUL:  alu_res = prod_w;
      // Divide-by-zero saturates the quotient to all ones.
      default: alu_res = {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
    endcase
  end

  combi_div_seq #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (bus.i_a),
    .divisor   (bus.i_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (div_load) begin
              state <= ST_CALC;
            end else begin
              state    <= ST_DONE;
              valid_q  <= 1'b1;
              result_q <= alu_res;
              rem_q    <= (bus.i_op == OP_DIV) ? bus.i_a : '0;
              dbz_q    <= (bus.i_op == OP_DIV);
            end
          end
        end
        ST_CALC: begin
          if (div_busy && div_done) begin
            state    <= ST_DONE;
            valid_q  <= 1'b1;
            result_q <= (2*DATA_W)'(div_quo);
            rem_q    <= div_rem;
            dbz_q    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_result      = result_q;
  assign bus.o_rem         = rem_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_combi_seq_alu.sv
// tb/tb_combi_seq_alu.sv - directed self-checking bench for combi_seq_alu
module tb_combi_seq_alu;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  combi_seq_alu_if #(.DATA_W(8)) bus();

  combi_seq_alu #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_ready = rdy;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    total++; if (bus.o_result !== 16'd0) begin bad++; $display("FAIL reset_result got %0d exp 0", bus.o_result); end
    total++; if (bus.o_rem !== 8'd0) begin bad++; $display("FAIL reset_rem got %0d exp 0", bus.o_rem); end
    total++; if (bus.o_div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got %b exp 0", bus.o_div_by_zero); end
  endtask

  task automatic test_add();
    issue(2'b00, 8'd30, 8'd10, 1'b1);
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL add_valid got %b exp 1", bus.o_valid); end
    total++; if (bus.o_result !== 16'd40) begin bad++; $display("FAIL add_result got %0d exp 40", bus.o_result); end
    total++; if (bus.o_rem !== 8'd0 || bus.o_div_by_zero !== 1'b0) begin
      bad++; $display("FAIL add_side got rem=%0d dbz=%b exp rem=0 dbz=0", bus.o_rem, bus.o_div_by_zero); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL add_busy got %b exp 0", bus.o_ready); end
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL add_release got ready=%b valid=%b exp 1/0", bus.o_ready, bus.o_valid); end
  endtask

  task automatic test_widths();
    logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b10};
    logic [7:0]  as  [3] = '{8'd10, 8'd255, 8'd255};
    logic [7:0]  bs  [3] = '{8'd30, 8'd255, 8'd255};
    logic [15:0] exp [3] = '{16'd236, 16'd510, 16'd65025};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      total++; if (bus.o_valid !== 1'b1 || bus.o_result !== exp[i]) begin
        bad++; $display("FAIL width_%0d got valid=%b result=%0d exp 1/%0d", i, bus.o_valid, bus.o_result, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [7:0] as [2] = '{8'd30, 8'd200};
    logic [7:0] bs [2] = '{8'd10, 8'd7};
    logic [7:0] eq [2] = '{8'd3, 8'd28};
    logic [7:0] er [2] = '{8'd0, 8'd4};
    for (int i = 0; i < 2; i++) begin
      issue(2'b11, as[i], bs[i], 1'b1);
      for (int k = 1; k <= 8; k++) begin
        total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
          bad++; $display("FAIL div%0d_calc_%0d got valid=%b ready=%b exp 0/0", i, k, bus.o_valid, bus.o_ready); end
        bus.i_valid = k[0];
        @(negedge clk);
      end
      bus.i_valid = 1'b0;
      total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL div%0d_valid got %b exp 1", i, bus.o_valid); end
      total++; if (bus.o_result !== {8'd0, eq[i]} || bus.o_rem !== er[i] || bus.o_div_by_zero !== 1'b0) begin
        bad++; $display("FAIL div%0d_value got q=%0d r=%0d dbz=%b exp %0d/%0d/0",
                        i, bus.o_result, bus.o_rem, bus.o_div_by_zero, eq[i], er[i]); end
      @(negedge clk);
      total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL div%0d_release got %b exp 1", i, bus.o_ready); end
    end
  endtask

  task automatic test_div_zero();
    issue(2'b11, 8'd30, 8'd0, 1'b1);
    total++; if (bus.o_valid !== 1'b1 || bus.o_div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_flag got valid=%b dbz=%b exp 1/1", bus.o_valid, bus.o_div_by_zero); end
    total++; if (bus.o_result !== 16'd255 || bus.o_rem !== 8'd30) begin
      bad++; $display("FAIL dbz_value got q=%0d r=%0d exp 255/30", bus.o_result, bus.o_rem); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    issue(2'b10, 8'd12, 8'd12, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid = ~bus.i_valid;
      bus.i_a     = 8'(k * 37 + 5);
      bus.i_b     = 8'(k * 11 + 3);
      total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 16'd144 || bus.o_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got valid=%b result=%0d ready=%b exp 1/144/0",
                        k, bus.o_valid, bus.o_result, bus.o_ready); end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_ready); end
  endtask

  task automatic test_reset_mid_div();
    issue(2'b11, 8'd250, 8'd3, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_result !== 16'd0 || bus.o_rem !== 8'd0) begin
      bad++; $display("FAIL abort_state got valid=%b ready=%b q=%0d r=%0d exp 0/1/0/0",
                      bus.o_valid, bus.o_ready, bus.o_result, bus.o_rem); end
    issue(2'b00, 8'd1, 8'd2, 1'b0);
    total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 16'd3) begin
      bad++; $display("FAIL abort_next got valid=%b result=%0d exp 1/3", bus.o_valid, bus.o_result); end
    repeat (8) @(negedge clk);
    total++; if (bus.o_result !== 16'd3 || bus.o_rem !== 8'd0) begin
      bad++; $display("FAIL abort_stale got result=%0d rem=%0d exp 3/0", bus.o_result, bus.o_rem); end
    bus.i_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.i_op = 2'b00; bus.i_a = 8'd5; bus.i_b = 8'd6; bus.i_ready = 1'b1; bus.i_valid = 1'b1;
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 16'd11) begin
      bad++; $display("FAIL b2b_first got valid=%b result=%0d exp 1/11", bus.o_valid, bus.o_result); end
    bus.i_a = 8'd7; bus.i_b = 8'd8;
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got ready=%b valid=%b exp 1/0", bus.o_ready, bus.o_valid); end
    @(negedge clk);
    bus.i_valid = 1'b0;
    total++; if (bus.o_valid !== 1'b1 || bus.o_result !== 16'd15) begin
      bad++; $display("FAIL b2b_second got valid=%b result=%0d exp 1/15", bus.o_valid, bus.o_result); end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_a     = 8'd0;
    bus.i_b     = 8'd0;
    bus.i_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_widths();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/combi_seq_alu.md
Name: combi_seq_alu

Overview:
- Registered, handshaked arithmetic stage that sits directly downstream of the operand source and replaces the pure combinational add/sub/mul/div path with a clocked unit.
- Accepts one operand pair plus an opcode per transaction.
- Computes add, sub and mul in one cycle; computes div with a multi-cycle restoring shift-subtract loop.
- Holds the result until the consumer accepts it.

Parameters:
- DATA_W, 8, operand width in bits; the result bus is 2*DATA_W wide.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream has a valid operand pair and opcode.
- o_ready  output  1  block can accept a new operation this cycle.
- i_op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- i_a  input  DATA_W  operand A, unsigned.
- i_b  input  DATA_W  operand B, unsigned.
- o_valid  output  1  result registers hold a valid result.
- i_ready  input  1  downstream accepts the result this cycle.
- o_result  output  2*DATA_W  ADD/SUB/MUL result, or DIV quotient, zero-extended.
- o_rem  output  DATA_W  DIV remainder; 0 for all other ops.
- o_div_by_zero  output  1  set with o_valid when a DIV had i_b == 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset:
  - state = IDLE.
  - o_ready = 1, o_valid = 0, o_result = 0, o_rem = 0, o_div_by_zero = 0.
  - Internal counter and work registers cleared.
  - Reset overrides every other input and aborts any operation in flight; no result is emitted for it.
- Accept: an operation is accepted when i_valid && o_ready on a rising edge. i_op, i_a and i_b are captured on that edge.
- States:
  - IDLE: o_ready = 1.
    - Accepted ADD, SUB or MUL: result computed from the captured operands and registered; go to DONE.
    - Accepted DIV with i_b != 0: load remainder = 0, quotient = i_a, counter = DATA_W; go to CALC.
    - Accepted DIV with i_b == 0: o_result = {DATA_W zeros, all-ones}, o_rem = i_a, o_div_by_zero = 1; go to DONE.
  - CALC: o_ready = 0. One restoring step per cycle:
    - shift {rem, quo} left by 1;
    - if rem >= b, rem -= b and quo[0] = 1;
    - counter decrements by 1.
    - When the counter reaches 0, register o_result = quotient and o_rem = remainder; go to DONE.
  - DONE: o_valid = 1, o_ready = 0.
    - o_result, o_rem and o_div_by_zero are held stable while i_ready = 0.
    - On i_ready = 1, go to IDLE next cycle: o_valid drops and o_ready rises.
- Latency, counted from the accept edge T:
  - ADD/SUB/MUL and DIV-by-zero: o_valid high from cycle T+1.
  - DIV: o_valid high from cycle T+1+DATA_W (9 cycles for DATA_W = 8).
- Throughput: at most one operation every 2 cycles. There is no same-cycle accept while in DONE.
- Width rules:
  - ADD: DATA_W+1-bit sum, zero-extended.
  - SUB: DATA_W-bit wrap-around (mod 2^DATA_W), zero-extended.
  - MUL: full 2*DATA_W-bit product.
  - DIV: DATA_W-bit quotient, zero-extended.
- o_div_by_zero is 0 for every op except DIV-by-zero.
- Inputs while busy: i_valid and operand changes while o_ready = 0 are ignored and do not disturb the operation in flight.
- Back-to-back: i_valid held high across DONE→IDLE is accepted on the first IDLE cycle.

Decomposition:
- Package combi_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV (2 bits);
  - state encodings ST_IDLE, ST_CALC, ST_DONE;
  - default DATA_W.
- Sub-module combi_div_seq: restoring divider datapath.
  - Inputs: load, dividend, divisor.
  - Outputs: busy, done pulse, quotient, remainder.
  - Iteration counter lives here.
  - The top level owns the FSM, the handshake and the result mux.

Test Plan:
- Reset then ADD, i_a=30, i_b=10, i_ready=1: o_valid at T+1, o_result=40, o_rem=0, o_div_by_zero=0; o_ready back to 1 at T+2.
- SUB 10-30 and ADD 255+255: o_result=236 (wrap), then o_result=510 (9-bit sum); MUL 255*255: o_result=65025.
- DIV 30/10 then DIV 200/7:
  - first: o_valid exactly at T+9, o_result=3, o_rem=0;
  - second: o_result=28, o_rem=4;
  - o_ready=0 throughout CALC.
- DIV 30/0: o_valid at T+1, o_result=255, o_rem=30, o_div_by_zero=1.
- Backpressure: MUL 12*12 with i_ready=0 for 5 cycles, with i_a/i_b/i_valid toggled meanwhile: o_result stays 144 with o_valid=1; clears the cycle after i_ready=1.
- Reset mid-DIV: assert reset at T+4 of DIV 250/3: next cycle o_valid=0, o_ready=1, outputs 0; a following ADD 1+2 returns 3 at T'+1.
